// File: rtl/flex_counter_pkg.sv
`default_nettype none
//==============================================================================
// Module      : flex_counter_pkg
// Description : Shared types for the multi-channel flexible counter.
// Revision    : 1.0 - initial release
//==============================================================================
package flex_counter_pkg;

    typedef enum logic [1:0] {
        CNT_UP_WRAP   = 2'b00,
        CNT_DOWN_WRAP = 2'b01,
        CNT_UP_SAT    = 2'b10,
        CNT_RSVD      = 2'b11
    } cnt_mode_t;

endpackage : flex_counter_pkg
`default_nettype wire

// File: rtl/flex_counter_ch.sv
`default_nettype none
//==============================================================================
// Module      : flex_counter_ch
// Description : One counter channel: up-wrap, down-wrap or up-saturate, with
//               clear/load, registered terminal flag and one-cycle wrap pulse.
// Revision    : 1.0 - initial release
//==============================================================================
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int WRAP_TO_ONE  = 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    count_enable,
    input  logic [1:0]              mode,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] c_START =
        {{(NUM_CNT_BITS-1){1'b0}}, (WRAP_TO_ONE != 0)};
    localparam logic [NUM_CNT_BITS-1:0] c_ONE =
        {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    logic                    r_pulse;

    logic [NUM_CNT_BITS-1:0] w_next;
    logic [NUM_CNT_BITS-1:0] w_terminal;
    logic                    w_wrap;
    cnt_mode_t               w_mode;

    assign w_mode = cnt_mode_t'(mode);

    always_comb begin
        w_next     = r_count;
        w_wrap     = 1'b0;
        w_terminal = (w_mode == CNT_DOWN_WRAP) ? c_START : rollover_val;

        if (clear) begin
            w_next = '0;
        end else if (load) begin
            w_next = load_val;
        end else if (count_enable) begin
            // The >= / <= compares also catch a terminal moved past the count.
            case (w_mode)
                CNT_UP_WRAP: begin
                    if (r_count >= rollover_val) begin
                        w_next = c_START;
                        w_wrap = 1'b1;
                    end else begin
                        w_next = r_count + c_ONE;
                    end
                end
                CNT_DOWN_WRAP: begin
                    if (r_count <= c_START) begin
                        w_next = rollover_val;
                        w_wrap = 1'b1;
                    end else begin
                        w_next = r_count - c_ONE;
                    end
                end
                CNT_UP_SAT: begin
                    if (r_count >= rollover_val) begin
                        w_next = rollover_val;
                    end else begin
                        w_next = r_count + c_ONE;
                    end
                end
                default: begin
                    w_next = r_count;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_count <= w_next;
            r_flag  <= (w_next == w_terminal);
            r_pulse <= w_wrap;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;
    assign wrap_pulse    = r_pulse;

endmodule : flex_counter_ch
`default_nettype wire

// File: rtl/flex_counter_mc.sv
`default_nettype none
//==============================================================================
// Module      : flex_counter_mc
// Description : NUM_CH independent flexible counters; slices the packed
//               per-channel buses onto flex_counter_ch instances.
// Revision    : 1.0 - initial release
//==============================================================================
module flex_counter_mc
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2,
    parameter int WRAP_TO_ONE  = 1
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [2*NUM_CH-1:0]            mode,
    input  logic [NUM_CNT_BITS*NUM_CH-1:0] load_val,
    input  logic [NUM_CNT_BITS*NUM_CH-1:0] rollover_val,
    output logic [NUM_CNT_BITS*NUM_CH-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              wrap_pulse
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_ch #(
            .NUM_CNT_BITS (NUM_CNT_BITS),
            .WRAP_TO_ONE  (WRAP_TO_ONE)
        ) u_ch (
            .clk           (clk),
            .n_rst         (n_rst),
            .clear         (clear[i]),
            .load          (load[i]),
            .count_enable  (count_enable[i]),
            .mode          (mode[2*i +: 2]),
            .load_val      (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_val  (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_out     (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_flag (rollover_flag[i]),
            .wrap_pulse    (wrap_pulse[i])
        );
    end

endmodule : flex_counter_mc
`default_nettype wire
